ula_seq: RTL and testbench
==========================

# ula_seq

Parametrised, clocked successor to the combinational ALU in the MIPS datapath. It executes the same 4-bit `controle` operation set on `WIDTH`-bit operands. Single-cycle operations are registered. Multiply and divide run iteratively and return a full double-width HI/LO result. A start/busy/done handshake lets the multicycle control unit stall on long operations.

## Interface
- `WIDTH`, 32: operand and result width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width; derived, do not override.

- `clock` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: operation request; sampled only while `busy`=0.
- `controle` input 4: operation code, captured with `start`.
- `in1` input `WIDTH`: operand A, captured with `start`.
- `in2` input `WIDTH`: operand B, captured with `start`.
- `busy` output 1: operation in progress; `start` is ignored while high.
- `done` output 1: one-cycle pulse when results become valid.
- `out_32` output `WIDTH`: primary result.
- `out_hi` output `WIDTH`: HI; product upper half or division remainder.
- `out_lo` output `WIDTH`: LO; product lower half or quotient.
- `out1` output 1: comparison flag.
- `div_zero` output 1: last division had `in2`=0.

## Operation
Codes:
- 0000: add.
- 0001: sub.
- 0010: mul.
- 0011: div.
- 0100: and.
- 0101: or.
- 0110: less-than; `out_32`=1/0, `out1` set.
- 0111: greater-than; `out1` only, `out_32`=0.
- 1000: equal; `out_32`=1/0, `out1` set.
- 1001: less-or-equal; `out_32`=1/0, `out1` set.
- 1010: greater-or-equal; `out1` only, `out_32`=0.
- 1011: `in1 << in2[SHW-1:0]`.
- 1100: logical right shift, `in1 >> in2[SHW-1:0]`.
- 1101: not-equal; `out1` only, `out_32`=0.
- 1110, 1111: all results 0, `out1`=0.

Result rules:
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- `out_hi`/`out_lo` are 0 for every operation except mul and div.
- Mul: shift-add, one partial-product bit per cycle; 2·WIDTH product into `out_hi`:`out_lo`; `out_32`=`out_lo`.
- Div: restoring division, one quotient bit per cycle; quotient→`out_lo` and `out_32`, remainder→`out_hi`.
- Div by zero: skips iteration; `div_zero`=1, `out_lo`=`out_32`=all ones, `out_hi`=`in1`.
- `div_zero` is cleared by any other accepted operation.

FSM:
- IDLE: `busy`=0. On `start`, capture operands and opcode.
  - Single-cycle op or div-by-zero → DONE.
  - Mul/div → CALC with iteration counter = WIDTH.
- CALC: `busy`=1. One iteration per cycle, counter decrements; counter reaching 0 → DONE, or → FIX when signed mode is enabled.
- FIX (signed builds only): `busy`=1, applies result sign correction → DONE.
- DONE: results registered, `done`=1, `busy`=0 → IDLE.
- A `start` in DONE is accepted exactly as in IDLE (back-to-back issue).

Result retention:
- Outputs hold until the next accepted operation's DONE.
- Outputs never show intermediate CALC values.

## Timing
- Reset values: `busy`=0, `done`=0, `out_32`=0, `out_hi`=0, `out_lo`=0, `out1`=0, `div_zero`=0; FSM→IDLE, counter=0.
- Reset during CALC/FIX aborts the operation with no `done` pulse.
- Latency from the `start` edge to `done` high:
  - Single-cycle ops and div-by-zero: 1 cycle.
  - Mul/div: WIDTH+1 cycles.
  - Mul/div in signed builds: WIDTH+2 cycles.
- `busy` rises the cycle after an accepted mul/div `start` and falls in the same cycle `done` rises.
- Throughput: one single-cycle op per clock when `start` is held high continuously.
- Operand or `controle` changes while `busy`=1 have no effect.

## Configuration
- `ULA_SEQ_SIGNED_EN` defined:
  - Comparisons treat operands as two's complement.
  - Mul/div operate on magnitudes, then FIX negates the results.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Undefined: all operations are unsigned and FIX is never entered.
- Shifts are always logical in both builds.

## Test plan
- Reset asserted during a mul in CALC → next cycle all outputs 0, `busy`=0, no `done` pulse.
- `start`, 0000, 0xFFFFFFFF + 1 → `done` after 1 cycle; `out_32`=0, `out_hi`=`out_lo`=0.
- `start`, 0010, 0xFFFFFFFF × 0xFFFFFFFF (unsigned) → `done` after 33 cycles; `out_hi`=0xFFFFFFFE, `out_lo`=0x00000001; `busy` high for 32 cycles.
- `start`, 0011, 100 / 7 → `out_lo`=14, `out_hi`=2; then 5 / 0 → `done` after 1 cycle, `div_zero`=1, `out_lo`=0xFFFFFFFF, `out_hi`=5.
- Second `start` pulsed mid-mul → ignored, and the first result is unchanged.
- Signed build: 0110 with -1 < 1 → `out1`=1. 0011 with -7 / 2 → `out_lo`=0xFFFFFFFD, `out_hi`=0xFFFFFFFF, `done` after 34 cycles. Unsigned build: -1 < 1 → `out1`=0.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: clocked ALU with registered single-cycle ops and iterative mul/div (HI/LO).
// Define ULA_SEQ_SIGNED_EN for two's-complement compares and signed mul/div.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       controle,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_32,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out1,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef ULA_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011,
    OP_AND = 4'b0100, OP_OR  = 4'b0101, OP_LT  = 4'b0110, OP_GT  = 4'b0111,
    OP_EQ  = 4'b1000, OP_LE  = 4'b1001, OP_GE  = 4'b1010, OP_SLL = 4'b1011,
    OP_SRL = 4'b1100, OP_NE  = 4'b1101
  } op_t;

  state_t           state, state_n;
  logic             accept, is_md;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             lt, gt, eq;

  // Single-cycle results
  logic [WIDTH-1:0] sc_32, sc_hi, sc_lo;
  logic             sc_1, sc_dz;

  // Iterative datapath
  logic             mul_q;
  logic             neg_q, neg_rem_q;
  logic [WIDTH-1:0] opb_q, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   msum, shifted, diff;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign is_md  = (controle == OP_MUL) || ((controle == OP_DIV) && (in2 != '0));

`ifdef ULA_SEQ_SIGNED_EN
  assign sign_a = in1[WIDTH-1];
  assign sign_b = in2[WIDTH-1];
  assign lt     = $signed(in1) < $signed(in2);
  assign gt     = $signed(in1) > $signed(in2);
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
  assign lt     = in1 < in2;
  assign gt     = in1 > in2;
`endif
  assign eq    = (in1 == in2);
  assign mag_a = sign_a ? (~in1 + 1'b1) : in1;
  assign mag_b = sign_b ? (~in2 + 1'b1) : in2;

  always_comb begin
    sc_32 = '0;
    sc_hi = '0;
    sc_lo = '0;
    sc_1  = 1'b0;
    sc_dz = 1'b0;
    case (controle)
      OP_ADD: sc_32 = in1 + in2;
      OP_SUB: sc_32 = in1 - in2;
      OP_DIV: begin
        // only reached here for a zero divisor
        sc_dz = 1'b1;
        sc_32 = '1;
        sc_lo = '1;
        sc_hi = in1;
      end
      OP_AND: sc_32 = in1 & in2;
      OP_OR:  sc_32 = in1 | in2;
      OP_LT:  begin sc_32 = WIDTH'(lt); sc_1 = lt; end
      OP_GT:  sc_1 = gt;
      OP_EQ:  begin sc_32 = WIDTH'(eq); sc_1 = eq; end
      OP_LE:  begin sc_32 = WIDTH'(lt | eq); sc_1 = lt | eq; end
      OP_GE:  sc_1 = gt | eq;
      OP_SLL: sc_32 = in1 << in2[SHW-1:0];
      OP_SRL: sc_32 = in1 >> in2[SHW-1:0];
      OP_NE:  sc_1 = ~eq;
      default: ;
    endcase
  end

  // Shift-add multiply step and restoring divide step share the accumulators.
  always_comb begin
    msum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (mul_q) begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], acc_lo[WIDTH-1:1]};
    end else begin
      step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_comb begin
    prod_neg = ~{acc_hi, acc_lo} + 1'b1;
    if (mul_q) begin
      fix_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi;
      fix_lo = neg_q ? prod_neg[WIDTH-1:0]       : acc_lo;
    end else begin
      fix_hi = neg_rem_q ? (~acc_hi + 1'b1) : acc_hi;
      fix_lo = neg_q     ? (~acc_lo + 1'b1) : acc_lo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (accept) state_n = is_md ? S_CALC : S_DONE;
        else        state_n = S_IDLE;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_n = SIGNED_EN ? S_FIX : S_DONE;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      out_32    <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      out1      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_md) begin
              mul_q     <= (controle == OP_MUL);
              opb_q     <= (controle == OP_MUL) ? mag_a : mag_b;
              acc_lo    <= (controle == OP_MUL) ? mag_b : mag_a;
              acc_hi    <= '0;
              cnt       <= CW'(WIDTH);
              neg_q     <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
            end else begin
              out_32   <= sc_32;
              out_hi   <= sc_hi;
              out_lo   <= sc_lo;
              out1     <= sc_1;
              div_zero <= sc_dz;
            end
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if ((cnt == CW'(1)) && !SIGNED_EN) begin
            out_32   <= step_lo;
            out_hi   <= step_hi;
            out_lo   <= step_lo;
            out1     <= 1'b0;
            div_zero <= 1'b0;
          end
        end
        S_FIX: begin
          out_32   <= fix_lo;
          out_hi   <= fix_hi;
          out_lo   <= fix_lo;
          out1     <= 1'b0;
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=32) against a plain-arithmetic reference model.
// Honours ULA_SEQ_SIGNED_EN to match the build under test.
module tb_ula_seq;

`ifdef ULA_SEQ_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  localparam int W      = 32;
  localparam int MD_LAT = SG ? W + 2 : W + 1;
  localparam int LIMIT  = 100;

  typedef struct packed {
    logic [31:0] o32;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        o1;
    logic        dz;
  } res_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  controle = '0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        busy, done, out1, div_zero;
  logic [31:0] out_32, out_hi, out_lo;

  int checks = 0;
  int errors = 0;

  ula_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .controle(controle),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out_32(out_32),
    .out_hi(out_hi), .out_lo(out_lo), .out1(out1), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb;
    logic [63:0] p;
    logic [4:0] sh;
    r  = '0;
    sa = SG ? longint'($signed(a)) : longint'(a);
    sb = SG ? longint'($signed(b)) : longint'(b);
    sh = b[4:0];
    case (op)
      4'd0: r.o32 = a + b;
      4'd1: r.o32 = a - b;
      4'd2: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; r.o32 = p[31:0]; end
      4'd3: begin
        if (b == 0) begin
          r.dz = 1'b1; r.lo = '1; r.o32 = '1; r.hi = a;
        end else begin
          p = sa / sb; r.lo = p[31:0]; r.o32 = p[31:0];
          p = sa % sb; r.hi = p[31:0];
        end
      end
      4'd4:  r.o32 = a & b;
      4'd5:  r.o32 = a | b;
      4'd6:  begin r.o1 = (sa < sb);  r.o32 = {31'd0, r.o1}; end
      4'd7:  r.o1 = (sa > sb);
      4'd8:  begin r.o1 = (sa == sb); r.o32 = {31'd0, r.o1}; end
      4'd9:  begin r.o1 = (sa <= sb); r.o32 = {31'd0, r.o1}; end
      4'd10: r.o1 = (sa >= sb);
      4'd11: r.o32 = a << sh;
      4'd12: r.o32 = a >> sh;
      4'd13: r.o1 = (sa != sb);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    return (op == 4'd2 || (op == 4'd3 && b != 0)) ? MD_LAT : 1;
  endfunction

  function automatic res_t observed();
    return {out_32, out_hi, out_lo, out1, div_zero};
  endfunction

  // Issues one operation and waits (bounded) for done; inputs are scrambled while it runs.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcyc, output res_t obs, output logic busy_at_done);
    @(negedge clock);
    start = 1'b1; controle = op; in1 = a; in2 = b;
    @(posedge clock); #1;
    start = 1'b0; controle = 4'($urandom); in1 = $urandom; in2 = $urandom;
    lat = 1; bcyc = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy === 1'b1) bcyc++;
      @(posedge clock); #1;
      lat++;
    end
    obs = observed();
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (observed() !== res_t'('0) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: outputs=%h busy=%b done=%b, required all 0", observed(), busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [9] = '{4'd0, 4'd2, 4'd3, 4'd3, 4'd6, 4'd3, 4'd11, 4'd12, 4'd7};
    logic [31:0] as  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd5, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'h1, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs  [9] = '{32'h1, 32'hFFFFFFFF, 32'd7, 32'd0, 32'h1, 32'd2, 32'd33, 32'd31, 32'h1};
    int lat, bcyc; res_t obs, exp; logic bd;
    for (int i = 0; i < 9; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      do_op(ops[i], as[i], bs[i], lat, bcyc, obs, bd);
      checks++;
      if (lat !== model_lat(ops[i], bs[i])) begin
        errors++;
        $display("FAIL directed%0d latency: got %0d required %0d", i, lat, model_lat(ops[i], bs[i]));
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL directed%0d result: got %h required %h", i, obs, exp);
      end
      checks++;
      if (bcyc !== model_lat(ops[i], bs[i]) - 1 || bd !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d busy: cycles %0d at_done %b required %0d and 0",
                 i, bcyc, bd, model_lat(ops[i], bs[i]) - 1);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcyc; res_t obs, exp; logic bd;
    logic [3:0] op; logic [31:0] v [2];
    logic [31:0] specials [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(15));
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(2))
          0: v[k] = $urandom;
          1: v[k] = 32'($urandom_range(15));
          default: v[k] = specials[$urandom_range(3)];
        endcase
      end
      exp = model(op, v[0], v[1]);
      do_op(op, v[0], v[1], lat, bcyc, obs, bd);
      checks++;
      if (lat !== model_lat(op, v[1]) || obs !== exp) begin
        errors++;
        $display("FAIL random%0d op%0d %h,%h: lat %0d res %h required lat %0d res %h",
                 i, op, v[0], v[1], lat, obs, model_lat(op, v[1]), exp);
      end
    end
  endtask

  task automatic test_hold();
    int lat, bcyc; res_t obs, exp; logic bd;
    exp = model(4'd3, 32'd1000, 32'd33);
    do_op(4'd3, 32'd1000, 32'd33, lat, bcyc, obs, bd);
    repeat (3) begin
      @(posedge clock); #1;
      in1 = $urandom; in2 = $urandom; controle = 4'($urandom);
    end
    checks++;
    if (done !== 1'b0 || observed() !== exp) begin
      errors++;
      $display("FAIL hold: done %b res %h required 0 and %h", done, observed(), exp);
    end
  endtask

  task automatic test_ignore_start();
    int lat; res_t exp; logic extra_done;
    exp = model(4'd2, 32'h12345678, 32'h9ABCDEF1);
    @(negedge clock);
    start = 1'b1; controle = 4'd2; in1 = 32'h12345678; in2 = 32'h9ABCDEF1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    repeat (5) begin @(posedge clock); #1; lat++; end
    @(negedge clock);
    start = 1'b1; controle = 4'd0; in1 = 32'd3; in2 = 32'd4;
    @(posedge clock); #1;
    start = 1'b0; lat++;
    while (done !== 1'b1 && lat < LIMIT) begin @(posedge clock); #1; lat++; end
    checks++;
    if (lat !== MD_LAT || observed() !== exp) begin
      errors++;
      $display("FAIL ignore_start: lat %0d res %h required lat %0d res %h", lat, observed(), MD_LAT, exp);
    end
    extra_done = 1'b0;
    repeat (3) begin @(posedge clock); #1; if (done === 1'b1) extra_done = 1'b1; end
    checks++;
    if (extra_done !== 1'b0 || observed() !== exp) begin
      errors++;
      $display("FAIL ignore_start_after: extra done %b res %h required 0 and %h", extra_done, observed(), exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcyc; res_t obs, exp; logic bd;
    logic [3:0] op; logic [31:0] a, b;
    do_op(4'd2, 32'd7, 32'd6, lat, bcyc, obs, bd);
    exp = model(4'd5, 32'hF0F0, 32'h0F0F);
    do_op(4'd5, 32'hF0F0, 32'h0F0F, lat, bcyc, obs, bd);
    checks++;
    if (lat !== 1 || obs !== exp) begin
      errors++;
      $display("FAIL b2b_after_mul: lat %0d res %h required 1 and %h", lat, obs, exp);
    end
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(15));
      if (op == 4'd2 || op == 4'd3) op = 4'd1;
      a = $urandom; b = (i % 3 == 0) ? a : $urandom;
      exp = model(op, a, b);
      @(negedge clock);
      start = 1'b1; controle = op; in1 = a; in2 = b;
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b1 || observed() !== exp) begin
        errors++;
        $display("FAIL b2b_held%0d op%0d: done %b res %h required 1 and %h", i, op, done, observed(), exp);
      end
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clock);
    start = 1'b1; controle = 4'd2; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (observed() !== res_t'('0) || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: outputs %h busy %b done %b required all 0", observed(), busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (W + 6) begin @(posedge clock); #1; if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_nodone: done/busy seen %b required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
